// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared state encoding for the UART frame echo buffer
package uart_echo_pkg;

    localparam int STATE_CODE_W = 3;

    typedef enum logic [STATE_CODE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } echo_state_e;

    function automatic logic [STATE_CODE_W-1:0] state_code_of(input echo_state_e s);
        return STATE_CODE_W'(s);
    endfunction

endpackage

// File: rtl/uart_frame_echo_if.sv
// rtl/uart_frame_echo_if.sv - rx/tx valid-ready handshake bundle between UART and echo buffer
interface uart_frame_echo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // master is the UART side, slave is the echo buffer
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - single-port frame RAM with synchronous write and registered read
module echo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [PTR_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Read register only updates on a read, so it holds the word during tx backpressure
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_echo.sv
// rtl/uart_frame_echo.sv - collects one UART frame into RAM and replays it forward or reversed
module uart_frame_echo
    import uart_echo_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 256,
    parameter bit                TERM_EN     = 1'b1,
    parameter logic [DATA_W-1:0] TERM_CHAR   = 8'h0A,
    parameter int                TIMEOUT_CYC = 1_000_000,
    localparam int               PTR_W       = $clog2(DEPTH),
    localparam int               CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    uart_frame_echo_if.slave        bus,
    input  logic                    reverse,
    output logic [CNT_W-1:0]        frame_len,
    output logic                    busy,
    output logic [STATE_CODE_W-1:0] state_code
);

    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    echo_state_e       state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]  frame_len_q, frame_len_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              rev_q, rev_d;
    logic              rx_ready_q, rx_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;

    logic              ram_en;
    logic              ram_we;
    logic [PTR_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    logic              rx_hs;
    logic              close;
    logic [CNT_W-1:0]  close_cnt;

    assign rx_hs = rx_ready_q && bus.rx_valid;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sent_d      = sent_q;
        frame_len_d = frame_len_q;
        idle_d      = idle_q;
        rev_d       = rev_q;
        rx_ready_d  = rx_ready_q;
        tx_valid_d  = tx_valid_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = wr_ptr_q;
        close       = 1'b0;
        close_cnt   = CNT_W'(wr_ptr_q);

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_RECV;
                rx_ready_d = 1'b1;
                wr_ptr_d   = '0;
                idle_d     = '0;
            end

            ST_RECV: begin
                if (rx_hs) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    idle_d    = '0;
                    close_cnt = CNT_W'(wr_ptr_q) + 1'b1;
                    if (wr_ptr_q == PTR_W'(DEPTH - 1) ||
                        (TERM_EN && bus.rx_data == TERM_CHAR)) begin
                        close = 1'b1;
                    end
                end else if (TIMEOUT_CYC > 0 && wr_ptr_q != '0) begin
                    // A handshake on the expiry cycle takes the branch above instead
                    if (idle_q == IDLE_MAX) begin
                        close = 1'b1;
                    end else if (idle_q != '1) begin
                        idle_d = idle_q + 1'b1;
                    end
                end

                if (close) begin
                    state_d     = ST_FETCH;
                    rx_ready_d  = 1'b0;
                    frame_len_d = close_cnt;
                    rev_d       = reverse;
                    sent_d      = '0;
                    rd_ptr_d    = reverse ? PTR_W'(close_cnt - 1'b1) : '0;
                end
            end

            ST_FETCH: begin
                ram_en     = 1'b1;
                ram_addr   = rd_ptr_q;
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (sent_q == frame_len_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        sent_d   = sent_q + 1'b1;
                        rd_ptr_d = rev_q ? rd_ptr_q - 1'b1 : rd_ptr_q + 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                wr_ptr_d   = '0;
                idle_d     = '0;
                sent_d     = '0;
                rx_ready_d = 1'b1;
                state_d    = ST_RECV;
            end

            default: begin
                state_d    = ST_IDLE;
                rx_ready_d = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        // Registered from next-state so it tracks state_q without a combinational output
        busy_d = !(state_d == ST_RECV && wr_ptr_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sent_q      <= '0;
            frame_len_q <= '0;
            idle_q      <= '0;
            rev_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sent_q      <= sent_d;
            frame_len_q <= frame_len_d;
            idle_q      <= idle_d;
            rev_q       <= rev_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
        end
    end

    echo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.rx_data),
        .rdata (ram_rdata)
    );

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = ram_rdata;
    assign frame_len    = frame_len_q;
    assign busy         = busy_q;
    assign state_code   = state_code_of(state_q);

endmodule
